// File: rtl/dram_port_arbiter.sv
// Two-port DRAM arbiter: grants one master at a time, routes DTACK to it and flags over-long grants.
// Define DRAM_ARB_ROUND_ROBIN_EN to resolve simultaneous requests round-robin instead of port-0 priority.
module dram_port_arbiter #(
    parameter int unsigned MaxHoldCycles = 1024
) (
    input  logic       Clock,
    input  logic       Reset_L,
    input  logic       Req0_L,
    input  logic       Req1_L,
    input  logic       DtackFromDram_L,
    output logic       Grant0_L,
    output logic       Grant1_L,
    output logic       MuxSel,
    output logic       DramSelect_L,
    output logic       Dtack0_L,
    output logic       Dtack1_L,
    output logic       HoldOverrun_H,
    output logic [1:0] ArbState
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_GRANT0  = 2'b01;
    localparam logic [1:0] ST_GRANT1  = 2'b10;
    localparam logic [1:0] ST_RELEASE = 2'b11;

    localparam logic [15:0] HOLD_LAST = 16'(MaxHoldCycles - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_hold_cnt;
    logic        r_overrun;
    logic        w_granted;
    logic        w_pick1;

`ifdef DRAM_ARB_ROUND_ROBIN_EN
    // Resets to "port 1 last", so the first contention after reset goes to port 0.
    logic r_last_grant1;

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_last_grant1 <= 1'b1;
        end else if (r_state == ST_IDLE && w_next_state == ST_GRANT0) begin
            r_last_grant1 <= 1'b0;
        end else if (r_state == ST_IDLE && w_next_state == ST_GRANT1) begin
            r_last_grant1 <= 1'b1;
        end
    end

    always_comb begin
        w_pick1 = !r_last_grant1;
    end
`else
    always_comb begin
        w_pick1 = 1'b0;
    end
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!Req0_L && !Req1_L) begin
                    w_next_state = w_pick1 ? ST_GRANT1 : ST_GRANT0;
                end else if (!Req0_L) begin
                    w_next_state = ST_GRANT0;
                end else if (!Req1_L) begin
                    w_next_state = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (Req0_L) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_GRANT1: begin
                if (Req1_L) begin
                    w_next_state = ST_RELEASE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_granted = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
    end

    // Counter value during grant cycle k is k-1, so the flag sets at the end of cycle MaxHoldCycles.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_hold_cnt <= '0;
            r_overrun  <= 1'b0;
        end else if (w_granted) begin
            if (r_hold_cnt != 16'hFFFF) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end
            if (r_hold_cnt == HOLD_LAST) begin
                r_overrun <= 1'b1;
            end
        end else begin
            r_hold_cnt <= '0;
        end
    end

    always_comb begin
        Grant0_L      = (r_state != ST_GRANT0);
        Grant1_L      = (r_state != ST_GRANT1);
        MuxSel        = (r_state == ST_GRANT1);
        DramSelect_L  = !w_granted;
        Dtack0_L      = (r_state == ST_GRANT0) ? DtackFromDram_L : 1'b1;
        Dtack1_L      = (r_state == ST_GRANT1) ? DtackFromDram_L : 1'b1;
        HoldOverrun_H = r_overrun;
        ArbState      = r_state;
    end

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 The block SHALL have parameter MaxHoldCycles, default 1024, setting the grant-hold cycle count at which the overrun flag sets.
REQ-002 The block SHALL have port Clock, input, 1, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port Reset_L, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port Req0_L, input, 1, active-low DRAM request from port 0 (cache controller), held low for the whole transfer.
REQ-005 The block SHALL have port Req1_L, input, 1, active-low DRAM request from port 1 (second bus master).
REQ-006 The block SHALL have port DtackFromDram_L, input, 1, active-low acknowledge from the DRAM controller.
REQ-007 The block SHALL have port Grant0_L, output, 1, active-low grant to port 0.
REQ-008 The block SHALL have port Grant1_L, output, 1, active-low grant to port 1.
REQ-009 The block SHALL have port MuxSel, output, 1, DRAM address/data/strobe mux select; 1 selects port 1.
REQ-010 The block SHALL have port DramSelect_L, output, 1, active-low select to the DRAM controller.
REQ-011 The block SHALL have port Dtack0_L, output, 1, acknowledge routed to port 0.
REQ-012 The block SHALL have port Dtack1_L, output, 1, acknowledge routed to port 1.
REQ-013 The block SHALL have port HoldOverrun_H, output, 1, sticky flag for a grant held for MaxHoldCycles or more.
REQ-014 The block SHALL have port ArbState, output, 2, current state for debugging.

Function
REQ-015 The FSM SHALL have states Idle=00, Grant0=01, Grant1=10 and Release=11, with state held in a register clocked on Clock.
REQ-016 In Idle, with Req0_L=0, the FSM SHALL go to Grant0; with only Req1_L=0, to Grant1; with neither, it SHALL stay in Idle.
REQ-017 In Grant0 or Grant1, the FSM SHALL stay while the granted port's request is low and go to Release on the first edge where it is high.
REQ-018 Release SHALL last exactly one cycle, SHALL go to Idle unconditionally, and any pending request SHALL be arbitrated in Idle.
REQ-019 Grant latency SHALL be one clock: a request sampled in Idle yields the grant in the next cycle; back-to-back requests cost 2 idle cycles (Release and Idle).
REQ-020 Grant0_L=0 only in Grant0, Grant1_L=0 only in Grant1, and DramSelect_L=0 only in Grant0/Grant1; all outputs SHALL decode from state, glitch-free.
REQ-021 MuxSel SHALL be 1 in Grant1 and 0 in all other states.
REQ-022 DtackN_L SHALL equal DtackFromDram_L combinationally while port N is granted and SHALL be 1 otherwise; the non-granted port never sees Dtack.
REQ-023 A 16-bit hold counter SHALL clear in every non-grant state, increment each grant cycle, and saturate at 16'hFFFF.
REQ-024 HoldOverrun_H SHALL set on the edge where the counter equals MaxHoldCycles-1 while still granted, and SHALL stay set until reset; a grant is never forcibly revoked.
REQ-025 A request withdrawn before its grant SHALL be ignored with no grant issued; a request arriving in Release SHALL be granted in the cycle after Idle.

Reset
REQ-026 While Reset_L=0, regardless of Clock, the block SHALL hold: state Idle, Grant0_L=1, Grant1_L=1, MuxSel=0, DramSelect_L=1, Dtack0_L=1, Dtack1_L=1, HoldOverrun_H=0, hold counter 0, ArbState=00.
REQ-027 A reset mid-grant SHALL drop the grant immediately; after release, the first edge evaluates as Idle.

Configuration
REQ-028 With macro DRAM_ARB_ROUND_ROBIN_EN defined, a last-granted register (reset 1) SHALL give a simultaneous Req0_L=0/Req1_L=0 in Idle to the port not last granted.
REQ-029 Without DRAM_ARB_ROUND_ROBIN_EN, port 0 SHALL have fixed priority per REQ-016, and no last-granted register SHALL be built.

Verification
REQ-030 The bench SHALL cover: Req0_L low 1 edge in Idle -> Grant0_L=0, DramSelect_L=0, MuxSel=0 next cycle; DtackFromDram_L=0 -> Dtack0_L=0, Dtack1_L=1.
REQ-031 The bench SHALL cover: Req0_L and Req1_L both low from Idle, macro undefined -> Grant0; Req0_L high -> Release, Idle, then Grant1 with MuxSel=1.
REQ-032 The bench SHALL cover: the same stimulus with macro defined, after reset -> Grant0 first; the second simultaneous contention after Grant0 -> Grant1.
REQ-033 The bench SHALL cover: MaxHoldCycles=8 with Req1_L held 10 cycles -> HoldOverrun_H=1 after the 8th grant cycle, grant kept, flag still 1 in Idle.
REQ-034 The bench SHALL cover: Reset_L pulsed low mid-Grant1, asynchronous to Clock -> Grant1_L=1, DramSelect_L=1, ArbState=00 before the next edge.
REQ-035 The bench SHALL cover: Req1_L low for exactly 1 cycle during Grant0 -> no Grant1 issued after Release.
